// File: rtl/io_interval_timer.sv
// Memory-mapped down-counting interval timer with a registered IRQ request/ack handshake.
// Defining TIMER_PRESCALE_EN adds the PRESC register at 0x010 and an 8-bit tick prescaler.
module io_interval_timer #(
   parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_cs,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [11:0] Address,
   input  logic [31:0] IO_in,
   output logic [31:0] IO_out,
   output logic        intr,
   input  logic        int_ack
);

   typedef enum logic [1:0] {StIdle, StAssert, StWaitRel} irq_state_e;

   irq_state_e  r_state, w_state_nxt;
   logic        r_en, r_auto, r_ie, r_pend, r_intr;
   logic [31:0] r_load, r_count;
   logic [9:0]  w_reg;
   logic        w_wr, w_ctrl_wr, w_load_wr, w_stat_wr;
   logic        w_tick_en, w_tick, w_expiry, w_ack;
   logic [31:0] w_rdata, w_presc_rd;
   logic        w_unused_addr;

   assign w_reg         = Address[11:2];
   assign w_unused_addr = ^Address[1:0];
   assign w_wr          = io_cs & io_wr;
   assign w_ctrl_wr     = w_wr & (w_reg == 10'd0);
   assign w_load_wr     = w_wr & (w_reg == 10'd1);
   assign w_stat_wr     = w_wr & (w_reg == 10'd3);

   // A software write to CTRL or LOAD owns the edge: no tick is taken alongside it.
   assign w_tick_en = r_en & ~w_ctrl_wr & ~w_load_wr;

`ifdef TIMER_PRESCALE_EN
   logic [7:0] r_presc, r_pcnt;
   logic       w_presc_wr;

   assign w_presc_wr = w_wr & (w_reg == 10'd4);
   assign w_tick     = w_tick_en & (r_pcnt == r_presc);
   assign w_presc_rd = {24'd0, r_presc};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= 8'd0;
         r_pcnt  <= 8'd0;
      end else begin
         if (w_presc_wr) r_presc <= IO_in[7:0];
         if (w_ctrl_wr || w_load_wr || !r_en || w_tick) r_pcnt <= 8'd0;
         else                                           r_pcnt <= r_pcnt + 8'd1;
      end
   end
`else
   assign w_tick     = w_tick_en;
   assign w_presc_rd = 32'd0;
`endif

   assign w_expiry = w_tick & (r_count == 32'd0);
   assign w_ack    = (r_state == StAssert) & int_ack;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en    <= 1'b0;
         r_auto  <= 1'b0;
         r_ie    <= 1'b0;
         r_load  <= RESET_LOAD;
         r_count <= RESET_LOAD;
      end else begin
         if (w_ctrl_wr)               {r_ie, r_auto, r_en} <= IO_in[2:0];
         else if (w_expiry && !r_auto) r_en <= 1'b0;

         if (w_load_wr) begin
            r_load  <= IO_in;
            r_count <= IO_in;
         end else if (w_expiry) begin
            r_count <= r_auto ? r_load : 32'd0;
         end else if (w_tick) begin
            r_count <= r_count - 32'd1;
         end
      end
   end

   // A new expiry beats any clear (ack or software) on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                r_pend <= 1'b0;
      else if (w_expiry)                         r_pend <= 1'b1;
      else if (w_ack || (w_stat_wr && IO_in[0])) r_pend <= 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
         r_intr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_intr  <= (w_state_nxt == StAssert);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:    if (r_pend && r_ie) w_state_nxt = StAssert;
         StAssert: begin
            if (int_ack)    w_state_nxt = StWaitRel;
            else if (!r_ie) w_state_nxt = StIdle;
         end
         StWaitRel: if (!int_ack) w_state_nxt = StIdle;
         default:   w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_rdata = 32'd0;
      case (w_reg)
         10'd0:   w_rdata = {29'd0, r_ie, r_auto, r_en};
         10'd1:   w_rdata = r_load;
         10'd2:   w_rdata = r_count;
         10'd3:   w_rdata = {31'd0, r_pend};
         10'd4:   w_rdata = w_presc_rd;
         default: w_rdata = 32'd0;
      endcase
   end

   assign IO_out = (io_cs && io_rd) ? w_rdata : 32'hzzzz_zzzz;
   assign intr   = r_intr;

endmodule
